// File: rtl/tmds_decoder.sv
// TMDS word aligner and decoder: bit-slip search on control tokens, then 2-stage decode.
// Optional lock-loss counter enabled by defining TMDS_DEC_ERRCNT_EN.
module tmds_decoder #(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOCK_TIMEOUT   = 2048
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic [9:0]  din,
    output logic [7:0]  dout,
    output logic [1:0]  ctl,
    output logic        de,
    output logic        locked,
    output logic [3:0]  offset,
    output logic [15:0] err_count
);
    localparam int RW = $clog2(TOKEN_RUN + 1);
    localparam int DW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    state_t        r_state;
    logic [9:0]    r_prev;
    logic [9:0]    r_s1;
    logic [RW-1:0] r_run;
    logic [DW-1:0] r_dwell;
    logic [WW-1:0] r_wd;
    logic [1:0]    r_ign;

    logic [19:0]   w_win;
    logic [9:0]    w_algn;
    logic          w_tok;
    logic [1:0]    w_tctl;
    logic [7:0]    w_d;
    logic [7:0]    w_pix;
    logic          w_drop;

    assign w_win  = {din, r_prev};
    assign w_algn = 10'(w_win >> offset);

    always_comb begin
        w_tok  = 1'b1;
        w_tctl = 2'b00;
        case (r_s1)
            10'b1101010100: w_tctl = 2'b00;
            10'b0010101011: w_tctl = 2'b01;
            10'b0101010100: w_tctl = 2'b10;
            10'b1010101011: w_tctl = 2'b11;
            default:        w_tok  = 1'b0;
        endcase
    end

    // Undo the transition-minimising XOR/XNOR chain and the optional inversion.
    always_comb begin
        w_pix    = '0;
        w_d      = r_s1[9] ? ~r_s1[7:0] : r_s1[7:0];
        w_pix[0] = w_d[0];
        for (int i = 1; i < 8; i++)
            w_pix[i] = w_d[i] ^ w_d[i-1] ^ ~r_s1[8];
    end

    assign w_drop = (r_state == S_LOCKED) && !w_tok && (r_wd == WW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_state <= S_SEARCH;
            r_prev  <= '0;
            r_s1    <= '0;
            r_run   <= '0;
            r_dwell <= '0;
            r_wd    <= '0;
            r_ign   <= '0;
            dout    <= '0;
            ctl     <= '0;
            de      <= 1'b0;
            locked  <= 1'b0;
            offset  <= '0;
        end else begin
            r_prev <= din;
            r_s1   <= w_algn;
            if (w_tok) begin
                ctl <= w_tctl;
                de  <= 1'b0;
            end else begin
                dout <= w_pix;
                de   <= 1'b1;
            end
            case (r_state)
                S_SEARCH: begin
                    if (r_ign == 2'd0 && w_tok && r_run == RW'(TOKEN_RUN - 1)) begin
                        r_state <= S_LOCKED;
                        locked  <= 1'b1;
                        r_run   <= '0;
                        r_dwell <= '0;
                        r_wd    <= '0;
                    end else if (r_dwell == DW'(SEARCH_TIMEOUT - 1)) begin
                        offset  <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                        r_dwell <= '0;
                        r_run   <= '0;
                        // Stage-1 words in flight were aligned with the old offset.
                        r_ign   <= 2'd2;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                        if (r_ign != 2'd0)
                            r_ign <= r_ign - 2'd1;
                        else if (w_tok)
                            r_run <= r_run + 1'b1;
                        else
                            r_run <= '0;
                    end
                end
                S_LOCKED: begin
                    if (w_tok) begin
                        r_wd <= '0;
                    end else if (w_drop) begin
                        r_state <= S_SEARCH;
                        locked  <= 1'b0;
                        r_wd    <= '0;
                        r_run   <= '0;
                        r_dwell <= '0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: r_state <= S_SEARCH;
            endcase
        end
    end

`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] r_err;
    always_ff @(posedge pixclk) begin
        if (reset)
            r_err <= '0;
        else if (w_drop && r_err != 16'hFFFF)
            r_err <= r_err + 16'd1;
    end
    assign err_count = r_err;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Random/directed bench for tmds_decoder: serial-stream generator, reference model, scoreboard.
module tb_tmds_decoder;
    localparam int TOKEN_RUN      = 8;
    localparam int SEARCH_TIMEOUT = 1024;
    localparam int LOCK_TIMEOUT   = 2048;

    logic        pixclk;
    logic        reset;
    logic [9:0]  din;
    logic [7:0]  dout;
    logic [1:0]  ctl;
    logic        de;
    logic        locked;
    logic [3:0]  offset;
    logic [15:0] err_count;

    tmds_decoder #(
        .TOKEN_RUN(TOKEN_RUN), .SEARCH_TIMEOUT(SEARCH_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .pixclk(pixclk), .reset(reset), .din(din), .dout(dout), .ctl(ctl), .de(de),
        .locked(locked), .offset(offset), .err_count(err_count)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    int total = 0;
    int bad   = 0;
    logic [31:0] expq[$];
    bit          bq[$];
    logic        run_mon = 1'b0;
    logic [9:0]  toks[4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0]  data_w  = 10'b0100000000;
    logic [9:0]  quiet_w = 10'b1000011111;

    // Reference model state (behavioural, post-edge values)
    logic [9:0] mp, ms1;
    logic [7:0] mdout;
    logic [1:0] mctl;
    logic       mde, mlock;
    int         moff, mrun, mdwell, mwd, msince, merr;

    function automatic int tok_idx(input logic [9:0] q);
        int r = -1;
        for (int i = 0; i < 4; i++) if (toks[i] == q) r = i;
        return r;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] q);
        logic [7:0] d, o;
        d = q[9] ? ~q[7:0] : q[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = (d[i] ^ d[i-1]) ^ !q[8];
        return o;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (tok_idx(w) >= 0);
        return w;
    endfunction

    task automatic model_step(input logic rst, input logic [9:0] w);
        int tk;
        logic [19:0] win;
        logic [9:0] s1n;
        if (rst) begin
            mp = '0; ms1 = '0; mdout = '0; mctl = '0; mde = 0; mlock = 0;
            moff = 0; mrun = 0; mdwell = 0; mwd = 0; msince = 2; merr = 0;
        end else begin
            win = {w, mp};
            s1n = win[moff +: 10];
            tk  = tok_idx(ms1);
            if (tk >= 0) begin mctl = 2'(tk); mde = 0; end
            else begin mdout = dec(ms1); mde = 1; end
            if (!mlock) begin
                if (msince >= 2 && tk >= 0 && mrun + 1 == TOKEN_RUN) begin
                    mlock = 1; mrun = 0; mdwell = 0; mwd = 0;
                end else if (mdwell + 1 == SEARCH_TIMEOUT) begin
                    moff = (moff + 1) % 10; mdwell = 0; mrun = 0; msince = 0;
                end else begin
                    mdwell++;
                    if (msince < 2) msince++;
                    else mrun = (tk >= 0) ? mrun + 1 : 0;
                end
            end else if (tk >= 0) begin
                mwd = 0;
            end else if (mwd + 1 == LOCK_TIMEOUT) begin
                mlock = 0; mwd = 0; mrun = 0; mdwell = 0;
`ifdef TMDS_DEC_ERRCNT_EN
                if (merr < 16'hFFFF) merr++;
`endif
            end else begin
                mwd++;
            end
            ms1 = s1n;
            mp  = w;
        end
        expq.push_back({mdout, mctl, mde, mlock, 4'(moff), 16'(merr)});
    endtask

    task automatic tick(input logic rst, input logic [9:0] w);
        @(negedge pixclk);
        reset = rst;
        din   = w;
        model_step(rst, w);
        run_mon = 1'b1;
        @(posedge pixclk);
        #2;
    endtask

    // Serialise a word into the bit stream and present the next 10 stream bits.
    task automatic send(input logic [9:0] w, input logic rst = 1'b0);
        logic [9:0] c;
        for (int i = 0; i < 10; i++) bq.push_back(w[i]);
        for (int i = 0; i < 10; i++) c[i] = bq.pop_front();
        tick(rst, c);
    endtask

    task automatic slip_stream(input int n);
        for (int i = 0; i < n; i++) bq.push_back(1'($urandom));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pattern(input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < 100; i++) send(toks[0]);
            for (int i = 0; i < 700; i++) send(rand_data());
        end
    endtask

    // Scoreboard monitor
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge pixclk);
            #1;
            if (run_mon) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty: got none want entry at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    if ({dout, ctl, de, locked, offset, err_count} !== e) begin
                        bad++;
                        $display("FAIL sb: got %h want %h at %0t",
                                 {dout, ctl, de, locked, offset, err_count}, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        din   = '0;
        for (int i = 0; i < 3; i++) tick(1'b1, 10'($urandom));
        chk("reset", {dout, ctl, de, locked, offset, err_count}, 32'h0);

        // Aligned lock, then first data word
        for (int i = 0; i < 8; i++) send(toks[0]);
        send(data_w);
        send(rand_data());
        chk("lock8", {31'h0, locked}, 32'h1);
        send(rand_data());
        chk("data29", {23'h0, dout, de}, {23'h0, 8'h00, 1'b1});

        // Each control token, dout must hold
        send(data_w);
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 3; i++) send(toks[t]);
            chk($sformatf("tok%0d", t), {21'h0, ctl, de, dout}, {21'h0, 2'(t), 1'b0, 8'h00});
        end

        for (int i = 0; i < 300; i++)
            send(($urandom_range(3) == 0) ? toks[$urandom_range(3)] : rand_data());

        // Watchdog drop
        send(toks[0]);
        for (int i = 0; i < 2049; i++) send(quiet_w);
        chk("wd_hold", {31'h0, locked}, 32'h1);
        send(quiet_w);
        chk("wd_drop", {31'h0, locked}, 32'h0);
`ifdef TMDS_DEC_ERRCNT_EN
        chk("errcnt", {16'h0, err_count}, 32'd1);
`else
        chk("errcnt", {16'h0, err_count}, 32'd0);
`endif
        chk("off_kept", {28'h0, offset}, 32'd0);

        // Rotated by 3
        slip_stream(3);
        pattern(7);
        chk("rot3", {27'h0, locked, offset}, {27'h0, 1'b1, 4'd3});

        // Lose lock, rotate to 5, relock, reset
        for (int i = 0; i < 2100; i++) send(rand_data());
        chk("drop2", {31'h0, locked}, 32'h0);
        slip_stream(2);
        pattern(5);
        chk("rot5", {27'h0, locked, offset}, {27'h0, 1'b1, 4'd5});
        send(toks[0], 1'b1);
        chk("rst_lock", {18'h0, locked, offset, dout, de}, 32'h0);

        // Offset wrap 9 -> 0 with no tokens
        for (int i = 0; i < 9 * SEARCH_TIMEOUT + 10; i++) send(rand_data());
        chk("off9", {27'h0, locked, offset}, {27'h0, 1'b0, 4'd9});
        for (int i = 0; i < SEARCH_TIMEOUT; i++) send(rand_data());
        chk("wrap0", {27'h0, locked, offset}, {27'h0, 1'b0, 4'd0});

        @(negedge pixclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
